// File: rtl/tsc_multicycle_cpu.sv
// Multicycle 16-bit TSC processor: IF/ID/EX/MEM/WB/HALT FSM sharing one
// request/acknowledge memory port for instruction fetch and data access.
module tsc_multicycle_cpu #(
    parameter int WORD_SIZE      = 16,
    parameter int RESET_PC       = 0,
    parameter int NUM_INST_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_cpu,
    input  logic                      cpu_enable,
    input  logic                      wwd_enable,
    input  logic [1:0]                register_selection,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [WORD_SIZE-1:0]      mem_addr,
    output logic [WORD_SIZE-1:0]      mem_wdata,
    input  logic [WORD_SIZE-1:0]      mem_rdata,
    input  logic                      mem_ack,
    output logic [WORD_SIZE-1:0]      output_port,
    output logic [WORD_SIZE-1:0]      pc_out,
    output logic [NUM_INST_WIDTH-1:0] num_inst,
    output logic                      halted
);

    localparam logic [3:0] OP_BNE = 4'd0, OP_BEQ = 4'd1, OP_BGZ = 4'd2, OP_BLZ = 4'd3,
                           OP_ADI = 4'd4, OP_ORI = 4'd5, OP_LHI = 4'd6, OP_LWD = 4'd7,
                           OP_SWD = 4'd8, OP_JMP = 4'd9, OP_JAL = 4'd10, OP_R = 4'd15;
    localparam logic [5:0] F_ADD = 6'd0, F_SUB = 6'd1, F_AND = 6'd2, F_ORR = 6'd3,
                           F_NOT = 6'd4, F_TCP = 6'd5, F_SHL = 6'd6, F_SHR = 6'd7,
                           F_JPR = 6'd25, F_JRL = 6'd26, F_WWD = 6'd28, F_HLT = 6'd29;

    typedef enum logic [2:0] {ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB, ST_HALT} state_t;

    state_t                    state_reg;
    logic [WORD_SIZE-1:0]      pc_reg, ir_reg, a_reg, b_reg, alu_reg, npc_reg, wwd_reg;
    logic [NUM_INST_WIDTH-1:0] num_inst_reg;
    logic                      fetch_busy_reg;
    logic [WORD_SIZE-1:0]      regs [4];
    logic [3:0]                reg_we;

    logic [3:0] op;
    logic [1:0] rs, rt, rd;
    logic [5:0] func;
    logic [7:0] imm;
    logic [11:0] target;
    assign op     = ir_reg[15:12];
    assign rs     = ir_reg[11:10];
    assign rt     = ir_reg[9:8];
    assign rd     = ir_reg[7:6];
    assign func   = ir_reg[5:0];
    assign imm    = ir_reg[7:0];
    assign target = ir_reg[11:0];

    logic [WORD_SIZE-1:0] pc_inc, imm_sext, imm_zext, alu_result, next_pc_ex;
    logic [1:0]           wr_idx;
    logic                 wr_en_dec, is_mem, is_wwd, is_halt;

    assign pc_inc   = pc_reg + WORD_SIZE'(1);
    assign imm_sext = WORD_SIZE'($signed(imm));
    assign imm_zext = WORD_SIZE'(imm);
    assign is_halt  = (op == OP_R) && (func == F_HLT);

    // Execute-stage decode: result, destination and successor PC of the instruction in ir_reg
    always_comb begin
        alu_result = '0;
        wr_en_dec  = 1'b0;
        wr_idx     = rt;
        is_mem     = 1'b0;
        is_wwd     = 1'b0;
        next_pc_ex = pc_inc;
        case (op)
            OP_R: begin
                wr_idx = rd;
                case (func)
                    F_ADD: begin alu_result = a_reg + b_reg; wr_en_dec = 1'b1; end
                    F_SUB: begin alu_result = a_reg - b_reg; wr_en_dec = 1'b1; end
                    F_AND: begin alu_result = a_reg & b_reg; wr_en_dec = 1'b1; end
                    F_ORR: begin alu_result = a_reg | b_reg; wr_en_dec = 1'b1; end
                    F_NOT: begin alu_result = ~a_reg; wr_en_dec = 1'b1; end
                    F_TCP: begin alu_result = ~a_reg + WORD_SIZE'(1); wr_en_dec = 1'b1; end
                    F_SHL: begin alu_result = a_reg << 1; wr_en_dec = 1'b1; end
                    F_SHR: begin alu_result = $signed(a_reg) >>> 1; wr_en_dec = 1'b1; end
                    F_JPR: next_pc_ex = a_reg;
                    F_JRL: begin
                        alu_result = pc_inc;
                        wr_en_dec  = 1'b1;
                        wr_idx     = 2'd2;
                        next_pc_ex = a_reg;
                    end
                    F_WWD: is_wwd = 1'b1;
                    default: ;
                endcase
            end
            OP_ADI: begin alu_result = a_reg + imm_sext; wr_en_dec = 1'b1; end
            OP_ORI: begin alu_result = a_reg | imm_zext; wr_en_dec = 1'b1; end
            OP_LHI: begin alu_result = WORD_SIZE'({imm, 8'h00}); wr_en_dec = 1'b1; end
            OP_LWD, OP_SWD: begin alu_result = a_reg + imm_sext; is_mem = 1'b1; end
            OP_BNE: if (a_reg != b_reg) next_pc_ex = pc_inc + imm_sext;
            OP_BEQ: if (a_reg == b_reg) next_pc_ex = pc_inc + imm_sext;
            OP_BGZ: if (!a_reg[WORD_SIZE-1] && (a_reg != '0)) next_pc_ex = pc_inc + imm_sext;
            OP_BLZ: if (a_reg[WORD_SIZE-1]) next_pc_ex = pc_inc + imm_sext;
            OP_JMP: next_pc_ex = {pc_inc[WORD_SIZE-1:12], target};
            OP_JAL: begin
                alu_result = pc_inc;
                wr_en_dec  = 1'b1;
                wr_idx     = 2'd2;
                next_pc_ex = {pc_inc[WORD_SIZE-1:12], target};
            end
            default: ;
        endcase
    end

    // A fetch, once raised, is held until acknowledged even if cpu_enable drops
    assign mem_req   = !reset_cpu && (((state_reg == ST_IF) && (cpu_enable || fetch_busy_reg))
                                      || (state_reg == ST_MEM));
    assign mem_we    = (state_reg == ST_MEM) && (op == OP_SWD);
    assign mem_addr  = (state_reg == ST_MEM) ? alu_reg : pc_reg;
    assign mem_wdata = b_reg;

    assign output_port = wwd_enable ? wwd_reg : regs[register_selection];
    assign pc_out      = pc_reg;
    assign num_inst    = num_inst_reg;
    assign halted      = (state_reg == ST_HALT);

    for (genvar gi = 0; gi < 4; gi++) begin : g_reg_we
        assign reg_we[gi] = (state_reg == ST_WB) && (wr_idx == 2'(gi));
    end

    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (reg_we[i]) regs[i] <= alu_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu) begin
            state_reg      <= ST_IF;
            pc_reg         <= WORD_SIZE'(RESET_PC);
            ir_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            alu_reg        <= '0;
            npc_reg        <= '0;
            wwd_reg        <= '0;
            num_inst_reg   <= '0;
            fetch_busy_reg <= 1'b0;
        end else begin
            fetch_busy_reg <= 1'b0;
            case (state_reg)
                ST_IF: begin
                    fetch_busy_reg <= mem_req && !mem_ack;
                    if (mem_req && mem_ack) begin
                        ir_reg    <= mem_rdata;
                        state_reg <= ST_ID;
                    end
                end
                ST_ID: begin
                    a_reg <= regs[rs];
                    b_reg <= regs[rt];
                    if (is_halt) begin
                        num_inst_reg <= num_inst_reg + NUM_INST_WIDTH'(1);
                        state_reg    <= ST_HALT;
                    end else begin
                        state_reg <= ST_EX;
                    end
                end
                ST_EX: begin
                    alu_reg <= alu_result;
                    npc_reg <= next_pc_ex;
                    if (is_mem) begin
                        state_reg <= ST_MEM;
                    end else if (wr_en_dec) begin
                        state_reg <= ST_WB;
                    end else begin
                        if (is_wwd) wwd_reg <= a_reg;
                        pc_reg       <= next_pc_ex;
                        num_inst_reg <= num_inst_reg + NUM_INST_WIDTH'(1);
                        state_reg    <= ST_IF;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (op == OP_SWD) begin
                            pc_reg       <= npc_reg;
                            num_inst_reg <= num_inst_reg + NUM_INST_WIDTH'(1);
                            state_reg    <= ST_IF;
                        end else begin
                            alu_reg   <= mem_rdata;
                            state_reg <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    pc_reg       <= npc_reg;
                    num_inst_reg <= num_inst_reg + NUM_INST_WIDTH'(1);
                    state_reg    <= ST_IF;
                end
                default: state_reg <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_tsc_multicycle_cpu.sv
// Directed bench for tsc_multicycle_cpu: a behavioural memory with settable
// acknowledge latency runs small hand-assembled programs.
module tb_tsc_multicycle_cpu;

    logic        clk;
    logic        reset_cpu;
    logic        cpu_enable;
    logic        wwd_enable;
    logic [1:0]  register_selection;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] output_port;
    logic [15:0] pc_out;
    logic [15:0] num_inst;
    logic        halted;

    tsc_multicycle_cpu dut (
        .clk                (clk),
        .reset_cpu          (reset_cpu),
        .cpu_enable         (cpu_enable),
        .wwd_enable         (wwd_enable),
        .register_selection (register_selection),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .mem_ack            (mem_ack),
        .output_port        (output_port),
        .pc_out             (pc_out),
        .num_inst           (num_inst),
        .halted             (halted)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:65535];
    int          mem_delay = 0;
    int          wait_cnt  = 0;
    int          wr_count  = 0;
    logic [15:0] wr_addr   = '0;
    logic [15:0] wr_data   = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: decides the acknowledge just after each falling edge
    always @(negedge clk) begin
        #1;
        if (mem_req && !reset_cpu) begin
            if (wait_cnt < mem_delay) begin
                mem_ack = 1'b0;
                wait_cnt++;
            end else begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    wr_count++;
                    wr_addr = mem_addr;
                    wr_data = mem_wdata;
                end else begin
                    mem_rdata = mem[mem_addr];
                end
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %0d %s: observed=%h expected=%h", checks, tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input logic we, input logic [1:0] sel);
        wwd_enable         = we;
        register_selection = sel;
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_cpu = 1'b1;
        cycles(2);
        reset_cpu = 1'b0;
    endtask

    initial begin
        reset_cpu          = 1'b1;
        cpu_enable         = 1'b0;
        wwd_enable         = 1'b0;
        register_selection = 2'd0;
        mem_rdata          = '0;
        mem_ack            = 1'b0;

        // Program 1: LHI/ADI/WWD, an undefined opcode, then HLT at pc 4
        clear_mem();
        mem[0] = 16'h6001;
        mem[1] = 16'h41FF;
        mem[2] = 16'hF41C;
        mem[3] = 16'hB000;
        mem[4] = 16'hF01D;
        cycles(3);
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_num_inst", num_inst, 16'h0000);
        chk("rst_halted", halted, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_output_port", output_port, 16'h0000);

        reset_cpu = 1'b0;
        cycles(2);
        chk("disabled_mem_req", mem_req, 1'b0);
        chk("disabled_pc", pc_out, 16'h0000);
        cpu_enable = 1'b1;
        cycles(11);
        chk("p1_num_inst_11cyc", num_inst, 16'd3);
        chk("p1_pc_11cyc", pc_out, 16'd3);
        show(1'b1, 2'd0);
        chk("p1_wwd_port", output_port, 16'h00FF);
        show(1'b0, 2'd1);
        chk("p1_reg1", output_port, 16'h00FF);
        show(1'b0, 2'd0);
        chk("p1_reg0_lhi", output_port, 16'h0100);
        cycles(3);
        chk("p1_nop_retired", num_inst, 16'd4);
        chk("p1_nop_pc", pc_out, 16'd4);
        cycles(2);
        chk("p1_halted", halted, 1'b1);
        chk("p1_hlt_retired", num_inst, 16'd5);
        for (int i = 0; i < 4; i++) begin
            cpu_enable = (i % 2 == 0);
            cycles(1);
            chk("p1_halt_no_req", mem_req, 1'b0);
        end
        cpu_enable = 1'b1;
        chk("p1_halt_pc", pc_out, 16'd4);
        chk("p1_still_halted", halted, 1'b1);

        // Program 2: ADD whose fetch is acknowledged after three wait cycles
        clear_mem();
        mem[0] = 16'h6012;
        mem[1] = 16'h4105;
        mem[2] = 16'hF1C0;
        mem[3] = 16'hF01D;
        do_reset();
        #1;
        chk("restart_halted", halted, 1'b0);
        chk("restart_pc", pc_out, 16'h0000);
        chk("restart_num_inst", num_inst, 16'd0);
        chk("restart_fetch_req", mem_req, 1'b1);
        chk("restart_fetch_addr", mem_addr, 16'h0000);
        cycles(8);
        mem_delay = 3;
        for (int i = 0; i < 4; i++) begin
            chk("wait_fetch_req", mem_req, 1'b1);
            chk("wait_fetch_addr", mem_addr, 16'd2);
            cycles(1);
        end
        chk("wait_req_dropped", mem_req, 1'b0);
        mem_delay = 0;
        cycles(2);
        chk("wait_add_not_yet", num_inst, 16'd2);
        cycles(1);
        chk("wait_add_retired", num_inst, 16'd3);
        chk("wait_add_pc", pc_out, 16'd3);
        show(1'b0, 2'd3);
        chk("wait_add_result", output_port, 16'h2405);

        // Program 3: BEQ taken, then the same program with BNE not taken
        clear_mem();
        mem[0]  = 16'h4005;
        mem[1]  = 16'h4505;
        mem[2]  = 16'h900A;
        mem[10] = 16'h1102;
        mem[11] = 16'hF01D;
        mem[13] = 16'hF01D;
        do_reset();
        cycles(11);
        chk("jmp_target_pc", pc_out, 16'd10);
        chk("jmp_target_addr", mem_addr, 16'd10);
        cycles(3);
        chk("beq_taken_pc", pc_out, 16'd13);
        chk("beq_taken_req", mem_req, 1'b1);
        chk("beq_taken_addr", mem_addr, 16'd13);
        mem[10] = 16'h0102;
        do_reset();
        cycles(14);
        chk("bne_fall_pc", pc_out, 16'd11);
        chk("bne_fall_addr", mem_addr, 16'd11);

        // Program 4: store then reload 0xBEEF at 0x20, then arithmetic shift right
        clear_mem();
        mem[0]    = 16'h61BE;
        mem[1]    = 16'h55EF;
        mem[2]    = 16'h4020;
        mem[3]    = 16'h8100;
        mem[4]    = 16'h7200;
        mem[5]    = 16'hF4C7;
        mem[6]    = 16'hF01D;
        mem[16'h20] = 16'h0000;
        wr_count  = 0;
        do_reset();
        cycles(15);
        chk("swd_req", mem_req, 1'b1);
        chk("swd_we", mem_we, 1'b1);
        chk("swd_addr", mem_addr, 16'h0020);
        chk("swd_wdata", mem_wdata, 16'hBEEF);
        cycles(1);
        chk("swd_retired", num_inst, 16'd4);
        chk("swd_write_count", wr_count, 32'd1);
        chk("swd_write_addr", wr_addr, 16'h0020);
        chk("swd_write_data", wr_data, 16'hBEEF);
        cycles(3);
        chk("lwd_req", mem_req, 1'b1);
        chk("lwd_we", mem_we, 1'b0);
        chk("lwd_addr", mem_addr, 16'h0020);
        cycles(2);
        chk("lwd_retired", num_inst, 16'd5);
        show(1'b0, 2'd2);
        chk("lwd_reg2", output_port, 16'hBEEF);
        cycles(4);
        show(1'b0, 2'd3);
        chk("shr_reg3", output_port, 16'hDF77);
        chk("shr_retired", num_inst, 16'd6);

        // Program 5: reset lands while a load waits for its acknowledge
        clear_mem();
        mem[0]      = 16'h4020;
        mem[1]      = 16'h7100;
        mem[16'h20] = 16'h1234;
        do_reset();
        cycles(7);
        mem_delay = 5;
        chk("lwdwait_req", mem_req, 1'b1);
        chk("lwdwait_addr", mem_addr, 16'h0020);
        cycles(2);
        chk("lwdwait_still_req", mem_req, 1'b1);
        chk("lwdwait_num_inst", num_inst, 16'd1);
        #2;
        reset_cpu = 1'b1;
        #1;
        chk("midreset_req_drop", mem_req, 1'b0);
        chk("midreset_num_inst", num_inst, 16'd0);
        chk("midreset_pc", pc_out, 16'h0000);
        show(1'b0, 2'd1);
        chk("midreset_rt", output_port, 16'h0000);
        cycles(2);
        chk("midreset_hold_req", mem_req, 1'b0);
        mem_delay = 0;
        reset_cpu = 1'b0;
        #1;
        chk("postreset_fetch_req", mem_req, 1'b1);
        chk("postreset_fetch_addr", mem_addr, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
